// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted load-use bubbles.
module id_ex_pipeline_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rd,
    input  logic                  if_id_uses_rt,
    input  logic [DATA_W-1:0]     id_rdata1,
    input  logic [DATA_W-1:0]     id_rdata2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [7:0]            id_ctrl,
    output logic [REG_ADDR_W-1:0] id_ex_rs,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [DATA_W-1:0]     id_ex_rdata1,
    output logic [DATA_W-1:0]     id_ex_rdata2,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic [7:0]            id_ex_ctrl,
    output logic                  id_ex_valid,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    // Control packing: {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp[1:0]}
    localparam int MEM_READ = 6;

    logic lu;
    logic rs_hit;
    logic rt_hit;
    logic count_full;

    always_comb begin
        rs_hit = (id_ex_rt == if_id_rs);
        rt_hit = if_id_uses_rt && (id_ex_rt == if_id_rt);
        lu     = id_ex_valid && id_ex_ctrl[MEM_READ] && (id_ex_rt != '0) && (rs_hit || rt_hit);
    end

    // Hold does not mask the stall: the load is still in EX, so IF/ID must not advance.
    assign stall      = lu & ~flush & ~reset;
    assign count_full = &stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_rs     <= '0;
            id_ex_rt     <= '0;
            id_ex_rd     <= '0;
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_imm    <= '0;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
            stall_count  <= '0;
        end else if (hold) begin
            id_ex_valid  <= id_ex_valid;
        end else if (flush || lu) begin
            // Zero specifiers keep the bubble invisible to forwarding and hazard logic.
            id_ex_rs     <= '0;
            id_ex_rt     <= '0;
            id_ex_rd     <= '0;
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_imm    <= '0;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
            if (!flush && !count_full) begin
                stall_count <= stall_count + 1'b1;
            end
        end else begin
            id_ex_rs     <= if_id_rs;
            id_ex_rt     <= if_id_rt;
            id_ex_rd     <= if_id_rd;
            id_ex_rdata1 <= id_rdata1;
            id_ex_rdata2 <= id_rdata2;
            id_ex_imm    <= id_imm;
            id_ex_ctrl   <= id_ctrl;
            id_ex_valid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_id_ex_pipeline_reg;

    localparam int W = 120;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        flush;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] rdata1, rdata2, imm;
    logic [7:0]  ctrl;

    logic [4:0]  o_rs, o_rt, o_rd;
    logic [31:0] o_d1, o_d2, o_imm;
    logic [7:0]  o_ctrl;
    logic        o_valid, o_stall;
    logic [15:0] o_cnt;

    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_d1, s_d2, s_imm;
    logic [7:0]  s_ctrl;
    logic        s_valid, s_stall;
    logic [3:0]  s_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the instruction sitting in EX plus bubble tallies.
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [7:0]  m_ctrl;
    int          m_cnt, m_cnt4;

    logic [W-1:0] exp_q[$];

    localparam logic [7:0] LW  = 8'hD8;
    localparam logic [7:0] ALU = 8'h82;

    id_ex_pipeline_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_rd(rd), .if_id_uses_rt(uses_rt),
        .id_rdata1(rdata1), .id_rdata2(rdata2), .id_imm(imm), .id_ctrl(ctrl),
        .id_ex_rs(o_rs), .id_ex_rt(o_rt), .id_ex_rd(o_rd),
        .id_ex_rdata1(o_d1), .id_ex_rdata2(o_d2), .id_ex_imm(o_imm),
        .id_ex_ctrl(o_ctrl), .id_ex_valid(o_valid), .stall(o_stall), .stall_count(o_cnt)
    );

    id_ex_pipeline_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_rd(rd), .if_id_uses_rt(uses_rt),
        .id_rdata1(rdata1), .id_rdata2(rdata2), .id_imm(imm), .id_ctrl(ctrl),
        .id_ex_rs(s_rs), .id_ex_rt(s_rt), .id_ex_rd(s_rd),
        .id_ex_rdata1(s_d1), .id_ex_rdata2(s_d2), .id_ex_imm(s_imm),
        .id_ex_ctrl(s_ctrl), .id_ex_valid(s_valid), .stall(s_stall), .stall_count(s_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A load in EX whose nonzero destination is read by the ID instruction.
    function automatic bit model_hazard();
        bool_load: begin end
        return m_valid && m_ctrl[6] && (m_rt != 5'd0) &&
               ((m_rt == rs) || (uses_rt && (m_rt == rt)));
    endfunction

    function automatic bit model_stall();
        return model_hazard() && !flush && !reset;
    endfunction

    function automatic logic [W-1:0] model_pack();
        return {m_valid, m_ctrl, m_rs, m_rt, m_rd, m_d1, m_d2, m_imm};
    endfunction

    task automatic model_update();
        bit hz;
        hz = model_hazard();
        if (reset) begin
            {m_valid, m_ctrl, m_rs, m_rt, m_rd, m_d1, m_d2, m_imm} = '0;
            m_cnt = 0;
            m_cnt4 = 0;
        end else if (hold) begin
            m_cnt = m_cnt;
        end else if (flush || hz) begin
            {m_valid, m_ctrl, m_rs, m_rt, m_rd, m_d1, m_d2, m_imm} = '0;
            if (!flush) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            end
        end else begin
            m_valid = 1'b1;
            m_ctrl = ctrl; m_rs = rs; m_rt = rt; m_rd = rd;
            m_d1 = rdata1; m_d2 = rdata2; m_imm = imm;
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                               input logic u, input logic [7:0] k);
        rs = a; rt = b; rd = c; uses_rt = u; ctrl = k;
        rdata1 = $urandom; rdata2 = $urandom; imm = $urandom;
    endtask

    task automatic test_reset();
        hold = 1'b0; flush = 1'b0;
        drive_instr(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 8'($urandom));
        reset = 1'b1;
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall_during: got %0b want 0", o_stall); end
        tick();
        drive_instr(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 8'($urandom));
        tick();
        n_checks++;
        if ({o_valid, o_ctrl, o_rs, o_rt, o_rd} !== 24'h0) begin
            n_errors++; $display("FAIL reset_regs: got %h want 0", {o_valid, o_ctrl, o_rs, o_rt, o_rd});
        end
        n_checks++;
        if ({o_d1, o_d2, o_imm} !== 96'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", {o_d1, o_d2, o_imm}); end
        n_checks++;
        if (o_cnt !== 16'd0 || s_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d/%0d want 0", o_cnt, s_cnt); end
        reset = 1'b0;
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall_after: got %0b want 0", o_stall); end
    endtask

    task automatic test_capture();
        drive_instr(5'd3, 5'd4, 5'd5, 1'b1, 8'h84);
        rdata1 = 32'h11;
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL capture_stall: got %0b want 0", o_stall); end
        tick();
        n_checks++;
        if ({o_valid, o_ctrl, o_rs, o_rt, o_rd} !== {1'b1, 8'h84, 5'd3, 5'd4, 5'd5}) begin
            n_errors++; $display("FAIL capture_fields: got %h want %h", {o_valid, o_ctrl, o_rs, o_rt, o_rd}, {1'b1, 8'h84, 5'd3, 5'd4, 5'd5});
        end
        n_checks++;
        if ({o_d1, o_d2, o_imm} !== {32'h11, rdata2, imm}) begin
            n_errors++; $display("FAIL capture_data: got %h want %h", {o_d1, o_d2, o_imm}, {32'h11, rdata2, imm});
        end
    endtask

    task automatic test_load_use();
        drive_instr(5'd1, 5'd8, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd8, 5'd2, 5'd10, 1'b1, ALU);
        settle();
        n_checks++;
        if (o_stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %0b want 1", o_stall); end
        tick();
        n_checks++;
        if ({o_valid, o_ctrl, o_rs, o_rt, o_rd} !== 24'h0) begin
            n_errors++; $display("FAIL lu_bubble: got %h want 0", {o_valid, o_ctrl, o_rs, o_rt, o_rd});
        end
        n_checks++;
        if (o_cnt !== 16'd1) begin n_errors++; $display("FAIL lu_count: got %0d want 1", o_cnt); end
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_len: got %0b want 0", o_stall); end
        tick();
        n_checks++;
        if ({o_valid, o_ctrl, o_rs, o_rt, o_rd} !== {1'b1, ALU, 5'd8, 5'd2, 5'd10}) begin
            n_errors++; $display("FAIL lu_resume: got %h want %h", {o_valid, o_ctrl, o_rs, o_rt, o_rd}, {1'b1, ALU, 5'd8, 5'd2, 5'd10});
        end
    endtask

    task automatic test_no_false_stall();
        drive_instr(5'd2, 5'd0, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd0, 5'd3, 5'd4, 1'b1, ALU);
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL nfs_rt0: got %0b want 0", o_stall); end
        tick();
        drive_instr(5'd1, 5'd9, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd1, 5'd9, 5'd6, 1'b0, ALU);
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL nfs_uses_rt: got %0b want 0", o_stall); end
        uses_rt = 1'b1;
        settle();
        n_checks++;
        if (o_stall !== 1'b1) begin n_errors++; $display("FAIL nfs_rt_hit: got %0b want 1", o_stall); end
        uses_rt = 1'b0;
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_rt !== 5'd9) begin n_errors++; $display("FAIL nfs_capture: got v=%0b rt=%0d want v=1 rt=9", o_valid, o_rt); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = m_cnt;
        drive_instr(5'd1, 5'd5, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd5, 5'd6, 5'd0, 1'b0, LW);
        settle();
        n_checks++;
        if (o_stall !== 1'b1) begin n_errors++; $display("FAIL b2b_stall1: got %0b want 1", o_stall); end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_stall !== 1'b0) begin n_errors++; $display("FAIL b2b_bubble1: got v=%0b s=%0b want 0/0", o_valid, o_stall); end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_rt !== 5'd6 || o_ctrl !== LW) begin
            n_errors++; $display("FAIL b2b_load2: got v=%0b rt=%0d c=%h want 1/6/%h", o_valid, o_rt, o_ctrl, LW);
        end
        drive_instr(5'd6, 5'd0, 5'd7, 1'b1, ALU);
        settle();
        n_checks++;
        if (o_stall !== 1'b1) begin n_errors++; $display("FAIL b2b_stall2: got %0b want 1", o_stall); end
        tick();
        n_checks++;
        if (o_cnt !== 16'(base + 2)) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", o_cnt, base + 2); end
        tick();
    endtask

    task automatic test_priority();
        int base;
        base = m_cnt;
        drive_instr(5'd1, 5'd8, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd8, 5'd2, 5'd3, 1'b1, ALU);
        flush = 1'b1;
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL prio_flush_stall: got %0b want 0", o_stall); end
        tick();
        flush = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ctrl !== 8'h0 || o_cnt !== 16'(base)) begin
            n_errors++; $display("FAIL prio_flush: got v=%0b c=%h n=%0d want 0/0/%0d", o_valid, o_ctrl, o_cnt, base);
        end
        drive_instr(5'd1, 5'd8, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd8, 5'd2, 5'd3, 1'b1, ALU);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (o_stall !== 1'b1) begin n_errors++; $display("FAIL prio_hold_stall: got %0b want 1", o_stall); end
            tick();
            n_checks++;
            if (o_valid !== 1'b1 || o_ctrl !== LW || o_rt !== 5'd8 || o_cnt !== 16'(base)) begin
                n_errors++; $display("FAIL prio_hold_frozen: got v=%0b c=%h rt=%0d n=%0d want 1/%h/8/%0d", o_valid, o_ctrl, o_rt, o_cnt, LW, base);
            end
        end
        hold = 1'b0;
        settle();
        n_checks++;
        if (o_stall !== 1'b1) begin n_errors++; $display("FAIL prio_hold_release: got %0b want 1", o_stall); end
        tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_cnt !== 16'(base + 1)) begin
            n_errors++; $display("FAIL prio_hold_bubble: got v=%0b n=%0d want 0/%0d", o_valid, o_cnt, base + 1);
        end
        drive_instr(5'd1, 5'd8, 5'd0, 1'b0, LW);
        tick();
        drive_instr(5'd8, 5'd2, 5'd3, 1'b1, ALU);
        reset = 1'b1;
        settle();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++; $display("FAIL prio_reset_stall: got %0b want 0", o_stall); end
        tick();
        reset = 1'b0;
        n_checks++;
        if ({o_valid, o_ctrl, o_rs, o_rt} !== 19'h0 || o_cnt !== 16'd0) begin
            n_errors++; $display("FAIL prio_reset_clear: got %h n=%0d want 0/0", {o_valid, o_ctrl, o_rs, o_rt}, o_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive_instr(5'd1, 5'd7, 5'd0, 1'b0, LW);
            tick();
            drive_instr(5'd7, 5'd2, 5'd3, 1'b1, ALU);
            tick();
        end
        n_checks++;
        if (s_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_count4: got %0d want 15", s_cnt); end
        n_checks++;
        if (o_cnt !== 16'(m_cnt) || m_cnt != 20) begin n_errors++; $display("FAIL sat_count16: got %0d want 20", o_cnt); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        for (int i = 0; i < 400; i++) begin
            drive_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                        1'($urandom), ($urandom_range(0, 1) != 0) ? LW : 8'($urandom));
            reset = ($urandom_range(0, 49) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            settle();
            n_checks++;
            if (o_stall !== model_stall()) begin n_errors++; $display("FAIL rand_stall[%0d]: got %0b want %0b", i, o_stall, model_stall()); end
            tick();
            exp_q.push_back(model_pack());
            exp = exp_q.pop_front();
            n_checks++;
            if ({o_valid, o_ctrl, o_rs, o_rt, o_rd, o_d1, o_d2, o_imm} !== exp) begin
                n_errors++; $display("FAIL rand_regs[%0d]: got %h want %h", i, {o_valid, o_ctrl, o_rs, o_rt, o_rd, o_d1, o_d2, o_imm}, exp);
            end
            n_checks++;
            if (o_cnt !== 16'(m_cnt) || s_cnt !== 4'(m_cnt4)) begin
                n_errors++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d/%0d", i, o_cnt, s_cnt, m_cnt, m_cnt4);
            end
        end
        reset = 1'b0; hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        {m_valid, m_ctrl, m_rs, m_rt, m_rd, m_d1, m_d2, m_imm} = '0;
        m_cnt = 0; m_cnt4 = 0;
        drive_instr(5'd0, 5'd0, 5'd0, 1'b0, 8'h0);
        test_reset();
        test_capture();
        test_load_use();
        test_no_false_stall();
        test_back_to_back();
        test_priority();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
